// File: rtl/stream_demux.sv
// stream_demux: routes one upstream valid/ready stream to four
// one-entry lane buffers, with a wrapping accepted-beat counter per lane.
module stream_demux #(
  parameter int DATA_WIDTH = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [1:0]              in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*DATA_WIDTH-1:0] out_data,
  output logic [3:0]              out_valid,
  input  logic [3:0]              out_ready,
  output logic [4*CNT_WIDTH-1:0]  out_count
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]            state;
  logic [DATA_WIDTH-1:0] data_q [4];
  logic [CNT_WIDTH-1:0]  cnt_q  [4];
  logic [3:0]            push;
  logic [3:0]            pop;

  // A full lane can still take a beat when it drains on the same edge.
  always_comb begin
    in_ready = rst_n &&
      ((state[in_sel] == EMPTY) || out_ready[in_sel]);
  end

  always_comb begin
    push = '0;
    for (int k = 0; k < 4; k++) begin
      push[k] = in_valid && in_ready && (in_sel == 2'(k));
    end
  end

  assign pop       = out_valid & out_ready;
  assign out_valid = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        state[k]  <= EMPTY;
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k]) begin
          state[k]  <= FULL;
          data_q[k] <= in_data;
          cnt_q[k]  <= cnt_q[k] + CNT_ONE;
        end else if (pop[k]) begin
          state[k] <= EMPTY;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
    assign out_count[g*CNT_WIDTH +: CNT_WIDTH]  = cnt_q[g];
  end

endmodule
